// File: rtl/fb_write_arbiter_if.sv
// fb_write_arbiter_if
//   Bundles every signal that the framebuffer write arbiter exchanges with its
//   neighbours. This covers the two requester valid/ready write channels, the
//   clear control and status, and the BRAM port A write bus.
//
//   Modports
//     master : the writers / surrounding system side. It drives the requests
//              and clear_start, and observes the readys, the clear status and
//              the BRAM bus.
//     slave  : the arbiter side.
//
//   Signals
//     req0_valid/ready/addr/data : requester 0 (pixel/draw engine) write channel
//     req1_valid/ready/addr/data : requester 1 (host/UART loader) write channel
//     clear_start                : one-cycle pulse requesting a full clear
//     clear_busy, clear_done     : clear status; done pulses with the last write
//     ena, wea, addra, dia       : BRAM port A write bus
interface fb_write_arbiter_if #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 10
);
  logic                     req0_valid;
  logic                     req0_ready;
  logic [ADDRESS_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0]    req0_data;

  logic                     req1_valid;
  logic                     req1_ready;
  logic [ADDRESS_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0]    req1_data;

  logic                     clear_start;
  logic                     clear_busy;
  logic                     clear_done;

  logic                     ena;
  logic                     wea;
  logic [ADDRESS_WIDTH-1:0] addra;
  logic [DATA_WIDTH-1:0]    dia;

  modport master (
    output req0_valid, req0_addr, req0_data,
    input  req0_ready,
    output req1_valid, req1_addr, req1_data,
    input  req1_ready,
    output clear_start,
    input  clear_busy, clear_done,
    input  ena, wea, addra, dia
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    output req0_ready,
    input  req1_valid, req1_addr, req1_data,
    output req1_ready,
    input  clear_start,
    output clear_busy, clear_done,
    output ena, wea, addra, dia
  );
endinterface

// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter
//   Shares port A (the write port) of the framebuffer dual-port BRAM between
//   requester 0 (draw engine) and requester 1 (host loader). Ties between the
//   two requesters are broken round-robin. An optional clear sequencer fills
//   every BRAM word with CLEAR_VALUE. Port B (scanout) is not touched here.
//
//   Every accepted write is registered. It appears on ena/wea/addra/dia in the
//   cycle after the handshake. In idle cycles, ena and wea are low while addra
//   and dia hold their last values.
//
//   Configuration macro: FB_ARB_CLEAR_EN
//     defined   : the clear sequencer (CLEAR state + address counter) is built.
//     undefined : no clear logic. clear_start is ignored and clear_busy and
//                 clear_done are tied low. The block is a pure arbiter.
//
//   Ports
//     i_clk   : single clock, shared with the BRAM
//     i_rst_n : asynchronous active-low reset
//     bus     : fb_write_arbiter_if.slave. It carries the requester
//               handshakes, the clear control/status and the BRAM port A
//               bus (ena, wea, addra, dia).
module fb_write_arbiter #(
  parameter int                    DATA_WIDTH  = 16,
  parameter int                    DATA_DEPTH  = 1024,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  fb_write_arbiter_if.slave bus
);

  localparam int ADDRESS_WIDTH = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;

  // r_last_grant holds the id of the most recent winner. Its reset value is 1,
  // so requester 0 wins the first tie.
  logic                     r_last_grant;
  logic                     w_pick0;
  logic                     w_pick1;
  logic                     w_grant0;
  logic                     w_grant1;
  logic                     w_clear_wr;
  logic [ADDRESS_WIDTH-1:0] w_clear_addr;
  logic                     w_wr_en;
  logic [ADDRESS_WIDTH-1:0] w_wr_addr;
  logic [DATA_WIDTH-1:0]    w_wr_data;
  logic                     r_ena;
  logic [ADDRESS_WIDTH-1:0] r_addra;
  logic [DATA_WIDTH-1:0]    r_dia;

  // Round-robin choice: a lone requester always wins. On a tie, the requester
  // that did not win last time is chosen.
  always_comb begin
    w_pick0 = bus.req0_valid;
    w_pick1 = bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      w_pick0 = r_last_grant;
      w_pick1 = ~r_last_grant;
    end
  end

`ifdef FB_ARB_CLEAR_EN
  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DATA_DEPTH - 1);

  state_t                   r_state;
  state_t                   w_state_next;
  logic [ADDRESS_WIDTH-1:0] r_clear_cnt;
  logic [ADDRESS_WIDTH-1:0] w_clear_cnt_next;
  logic                     w_done_next;
  logic                     r_done;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_clear_cnt <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_clear_cnt <= w_clear_cnt_next;
      r_done      <= w_done_next;
    end
  end

  // A clear start in IDLE wins over any pending request, and that cycle grants
  // nothing. The counter stops at the last real address instead of wrapping,
  // so a depth that is not a power of 2 never writes past the end of the BRAM.
  always_comb begin
    w_state_next     = r_state;
    w_clear_cnt_next = r_clear_cnt;
    w_done_next      = 1'b0;
    w_grant0         = 1'b0;
    w_grant1         = 1'b0;
    w_clear_wr       = 1'b0;
    w_clear_addr     = r_clear_cnt;
    case (r_state)
      ST_IDLE: begin
        if (bus.clear_start) begin
          w_state_next     = ST_CLEAR;
          w_clear_cnt_next = '0;
        end else begin
          w_grant0 = w_pick0;
          w_grant1 = w_pick1;
        end
      end
      ST_CLEAR: begin
        w_clear_wr = 1'b1;
        if (r_clear_cnt == LAST_ADDR) begin
          w_done_next  = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          w_clear_cnt_next = r_clear_cnt + 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Busy stays high until the final clear write has appeared on the bus.
  assign bus.clear_busy = (r_state == ST_CLEAR) || r_done;
  assign bus.clear_done = r_done;
`else
  logic w_unused_clear_start;

  assign w_unused_clear_start = bus.clear_start;
  assign w_grant0             = w_pick0;
  assign w_grant1             = w_pick1;
  assign w_clear_wr           = 1'b0;
  assign w_clear_addr         = '0;
  assign bus.clear_busy       = 1'b0;
  assign bus.clear_done       = 1'b0;
`endif

  assign bus.req0_ready = w_grant0;
  assign bus.req1_ready = w_grant1;

  // Select the single write issued this cycle (clear or winner). With no write,
  // the address and data hold their last values.
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_addr = r_addra;
    w_wr_data = r_dia;
    if (w_clear_wr) begin
      w_wr_en   = 1'b1;
      w_wr_addr = w_clear_addr;
      w_wr_data = CLEAR_VALUE;
    end else if (w_grant0) begin
      w_wr_en   = 1'b1;
      w_wr_addr = bus.req0_addr;
      w_wr_data = bus.req0_data;
    end else if (w_grant1) begin
      w_wr_en   = 1'b1;
      w_wr_addr = bus.req1_addr;
      w_wr_data = bus.req1_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_grant <= 1'b1;
      r_ena        <= 1'b0;
      r_addra      <= '0;
      r_dia        <= '0;
    end else begin
      r_ena <= w_wr_en;
      if (w_wr_en) begin
        r_addra <= w_wr_addr;
        r_dia   <= w_wr_data;
      end
      if (w_grant0) begin
        r_last_grant <= 1'b0;
      end else if (w_grant1) begin
        r_last_grant <= 1'b1;
      end
    end
  end

  assign bus.ena   = r_ena;
  assign bus.wea   = r_ena;
  assign bus.addra = r_addra;
  assign bus.dia   = r_dia;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb_fb_write_arbiter
//   Bench for fb_write_arbiter using a 600-word BRAM (not a power of 2) and a
//   non-zero clear word, so that clear writes are easy to tell apart.
//   A behavioural model (clear writes remaining, round-robin winner) predicts
//   the readys and the registered BRAM bus on every cycle. Directed sequences
//   pin the model with literal expectations. A randomized phase then follows.
//   Clear-related sequences are built when FB_ARB_CLEAR_EN is defined.
module tb_fb_write_arbiter;

  localparam int              DW    = 16;
  localparam int              DEPTH = 600;
  localparam int              AW    = $clog2(DEPTH);
  localparam logic [DW-1:0]   CLR   = 16'h5A3C;
`ifdef FB_ARB_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  logic clk  = 1'b0;
  logic rstN = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   grantLog[$];

  // Model state: number of clear writes still to issue, next clear address,
  // last winner, and the expected registered bus for the current cycle.
  int            mClearLeft;
  int            mClearAddr;
  int            mLastGrant;
  logic          expEna;
  logic [AW-1:0] expAddr;
  logic [DW-1:0] expData;
  logic          expDone;

  fb_write_arbiter_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

  fb_write_arbiter #(
    .DATA_WIDTH (DW),
    .DATA_DEPTH (DEPTH),
    .CLEAR_VALUE(CLR)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rstN),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                               input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                               input logic st);
    @(posedge clk);
    #1;
    bus.req0_valid  = v0;
    bus.req0_addr   = a0;
    bus.req0_data   = d0;
    bus.req1_valid  = v1;
    bus.req1_addr   = a1;
    bus.req1_data   = d1;
    bus.clear_start = st;
  endtask

  task automatic resetModel();
    mClearLeft = 0;
    mClearAddr = 0;
    mLastGrant = 1;
    expEna     = 1'b0;
    expAddr    = '0;
    expData    = '0;
    expDone    = 1'b0;
  endtask

  task automatic doReset();
    rstN            = 1'b0;
    bus.req0_valid  = 1'b0;
    bus.req0_addr   = '0;
    bus.req0_data   = '0;
    bus.req1_valid  = 1'b0;
    bus.req1_addr   = '0;
    bus.req1_data   = '0;
    bus.clear_start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("resetEna", 32'(bus.ena), 32'd0);
    checkOutput("resetBusy", 32'(bus.clear_busy), 32'd0);
    checkOutput("resetDone", 32'(bus.clear_done), 32'd0);
    checkOutput("resetAddr", 32'(bus.addra), 32'd0);
    repeat (2) @(posedge clk);
    #1 rstN = 1'b1;
  endtask

  // Compares the DUT against the model every cycle. Inputs settle 1ns after
  // the rising edge, and all sampling happens on the falling edge.
  initial begin : compareProc
    int            win;
    logic          eRdy0;
    logic          eRdy1;
    logic          pendWr;
    logic          pendDone;
    logic          startClear;
    logic [AW-1:0] pendAddr;
    logic [DW-1:0] pendData;
    resetModel();
    forever begin
      @(negedge clk);
      if (!rstN) begin
        resetModel();
        checkOutput("rstEna", 32'(bus.ena), 32'd0);
        checkOutput("rstBusy", 32'(bus.clear_busy), 32'd0);
        checkOutput("rstDia", 32'(bus.dia), 32'd0);
      end else begin
        win        = -1;
        eRdy0      = 1'b0;
        eRdy1      = 1'b0;
        pendWr     = 1'b0;
        pendDone   = 1'b0;
        startClear = 1'b0;
        pendAddr   = '0;
        pendData   = '0;
        if (mClearLeft > 0) begin
          pendWr   = 1'b1;
          pendAddr = AW'(mClearAddr);
          pendData = CLR;
          pendDone = (mClearLeft == 1);
        end else if (CLEAR_EN && bus.clear_start) begin
          startClear = 1'b1;
        end else begin
          if (bus.req0_valid && bus.req1_valid) win = 1 - mLastGrant;
          else if (bus.req0_valid)              win = 0;
          else if (bus.req1_valid)              win = 1;
          if (win == 0) begin
            eRdy0 = 1'b1; pendWr = 1'b1; pendAddr = bus.req0_addr; pendData = bus.req0_data;
          end else if (win == 1) begin
            eRdy1 = 1'b1; pendWr = 1'b1; pendAddr = bus.req1_addr; pendData = bus.req1_data;
          end
        end
        checkOutput("rdy0", 32'(bus.req0_ready), 32'(eRdy0));
        checkOutput("rdy1", 32'(bus.req1_ready), 32'(eRdy1));
        checkOutput("ena", 32'(bus.ena), 32'(expEna));
        checkOutput("wea", 32'(bus.wea), 32'(expEna));
        checkOutput("addra", 32'(bus.addra), 32'(expAddr));
        checkOutput("dia", 32'(bus.dia), 32'(expData));
        checkOutput("busy", 32'(bus.clear_busy), 32'((mClearLeft > 0) || expDone));
        checkOutput("done", 32'(bus.clear_done), 32'(expDone));
        @(posedge clk);
        if (!rstN) begin
          resetModel();
        end else begin
          expEna  = pendWr;
          expDone = pendDone;
          if (pendWr) begin
            expAddr = pendAddr;
            expData = pendData;
          end
          if (mClearLeft > 0) begin
            mClearLeft--;
            mClearAddr++;
          end
          if (startClear) begin
            mClearLeft = DEPTH;
            mClearAddr = 0;
          end
          if (win >= 0) begin
            mLastGrant = win;
            grantLog.push_back(win);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, wanted completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    logic          v0, v1, acc0, acc1, st;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    int            writes, seqErr, dataErr, doneCount, doneAddr, maxAddr, earlyGrants;
    bit            sawDone;

    doReset();

    // Single requester 0 write, then its registered appearance on the bus.
    applyStimulus(1'b1, 10'd5, 16'hABCD, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    checkOutput("t1Ready0", 32'(bus.req0_ready), 32'd1);
    checkOutput("t1EnaBefore", 32'(bus.ena), 32'd0);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    checkOutput("t1Ena", 32'(bus.ena), 32'd1);
    checkOutput("t1Wea", 32'(bus.wea), 32'd1);
    checkOutput("t1Addr", 32'(bus.addra), 32'd5);
    checkOutput("t1Data", 32'(bus.dia), 32'hABCD);

    // Both requesters valid for 4 cycles after reset: grants 0,1,0,1.
    doReset();
    grantLog.delete();
    applyStimulus(1'b1, 10'd10, 16'h1111, 1'b1, 10'd20, 16'h2222, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("t2Ready0", 32'(bus.req0_ready), 32'(k % 2 == 0));
      checkOutput("t2Ready1", 32'(bus.req1_ready), 32'(k % 2 == 1));
      if (k > 0) begin
        checkOutput("t2Ena", 32'(bus.ena), 32'd1);
        checkOutput("t2Addr", 32'(bus.addra), (k % 2 == 1) ? 32'd10 : 32'd20);
        checkOutput("t2Data", 32'(bus.dia), (k % 2 == 1) ? 32'h1111 : 32'h2222);
      end
      if (k < 3) applyStimulus(1'b1, 10'd10, 16'h1111, 1'b1, 10'd20, 16'h2222, 1'b0);
      else       applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    end
    @(negedge clk);
    checkOutput("t2LastEna", 32'(bus.ena), 32'd1);
    checkOutput("t2LastAddr", 32'(bus.addra), 32'd20);
    checkOutput("t2GrantCount", grantLog.size(), 32'd4);
    for (int k = 0; k < 4; k++)
      checkOutput("t2GrantSeq", (k < grantLog.size()) ? grantLog[k] : 99, 32'(k % 2));

    // Asynchronous reset in the middle of streaming writes.
    applyStimulus(1'b1, 10'd1, 16'h0101, 1'b1, 10'd2, 16'h0202, 1'b0);
    applyStimulus(1'b1, 10'd1, 16'h0101, 1'b1, 10'd2, 16'h0202, 1'b0);
    @(negedge clk);
    checkOutput("rstMidEnaBefore", 32'(bus.ena), 32'd1);
    #2 rstN = 1'b0;
    #1;
    checkOutput("rstMidEna", 32'(bus.ena), 32'd0);
    checkOutput("rstMidAddr", 32'(bus.addra), 32'd0);
    doReset();
    applyStimulus(1'b1, 10'd3, 16'h0303, 1'b1, 10'd4, 16'h0404, 1'b0);
    @(negedge clk);
    checkOutput("rstTieReady0", 32'(bus.req0_ready), 32'd1);
    checkOutput("rstTieReady1", 32'(bus.req1_ready), 32'd0);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);

`ifdef FB_ARB_CLEAR_EN
    // Full clear with no requesters.
    doReset();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    writes = 0; seqErr = 0; dataErr = 0; doneCount = 0; doneAddr = -1; maxAddr = -1; sawDone = 0;
    for (int c = 0; c < DEPTH + 10 && !sawDone; c++) begin
      @(negedge clk);
      if (bus.ena) begin
        if (int'(bus.addra) != writes) seqErr++;
        if (bus.dia != CLR) dataErr++;
        if (int'(bus.addra) > maxAddr) maxAddr = int'(bus.addra);
        writes++;
      end
      if (bus.clear_done) begin
        doneCount++;
        doneAddr = int'(bus.addra);
        sawDone  = 1;
      end
    end
    checkOutput("clrDoneSeen", 32'(sawDone), 32'd1);
    checkOutput("clrWrites", writes, DEPTH);
    checkOutput("clrSeqErr", seqErr, 32'd0);
    checkOutput("clrDataErr", dataErr, 32'd0);
    checkOutput("clrDoneCount", doneCount, 32'd1);
    checkOutput("clrDoneAddr", doneAddr, DEPTH - 1);
    checkOutput("clrMaxAddr", maxAddr, DEPTH - 1);
    @(negedge clk);
    checkOutput("clrBusyAfter", 32'(bus.clear_busy), 32'd0);
    checkOutput("clrEnaAfter", 32'(bus.ena), 32'd0);

    // Requester 1 held valid throughout a clear, with a second start mid-clear.
    applyStimulus(1'b0, '0, '0, 1'b1, 10'd77, 16'hBEEF, 1'b1);
    writes = 0; earlyGrants = 0; sawDone = 0;
    for (int c = 0; c < DEPTH + 20 && !sawDone; c++) begin
      @(negedge clk);
      if (bus.ena) writes++;
      if (bus.clear_done) begin
        sawDone = 1;
        checkOutput("t4Req1AfterClear", 32'(bus.req1_ready), 32'd1);
      end else begin
        if (bus.req1_ready) earlyGrants++;
        applyStimulus(1'b0, '0, '0, 1'b1, 10'd77, 16'hBEEF, 1'(c == 200));
      end
    end
    checkOutput("t4DoneSeen", 32'(sawDone), 32'd1);
    checkOutput("t4EarlyGrants", earlyGrants, 32'd0);
    checkOutput("t4Writes", writes, DEPTH);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    checkOutput("t4Req1Ena", 32'(bus.ena), 32'd1);
    checkOutput("t4Req1Addr", 32'(bus.addra), 32'd77);
    checkOutput("t4Req1Data", 32'(bus.dia), 32'hBEEF);
    checkOutput("t4BusyAfter", 32'(bus.clear_busy), 32'd0);

    // Reset while the clear is writing address 300.
    doReset();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    sawDone = 0;
    for (int c = 0; c < DEPTH + 10 && !sawDone; c++) begin
      @(negedge clk);
      if (bus.ena && bus.addra == 10'd300) sawDone = 1;
    end
    checkOutput("t6Reached300", 32'(sawDone), 32'd1);
    checkOutput("t6BusyBefore", 32'(bus.clear_busy), 32'd1);
    #2 rstN = 1'b0;
    #1;
    checkOutput("t6Ena", 32'(bus.ena), 32'd0);
    checkOutput("t6Busy", 32'(bus.clear_busy), 32'd0);
    checkOutput("t6Done", 32'(bus.clear_done), 32'd0);
    doReset();
    applyStimulus(1'b1, 10'd8, 16'h0808, 1'b1, 10'd9, 16'h0909, 1'b0);
    @(negedge clk);
    checkOutput("t6TieReady0", 32'(bus.req0_ready), 32'd1);
    checkOutput("t6TieReady1", 32'(bus.req1_ready), 32'd0);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
`else
    // Without the clear sequencer, a start pulse is ignored entirely.
    doReset();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    writes = 0; doneCount = 0; earlyGrants = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.ena) writes++;
      if (bus.clear_done) doneCount++;
      if (bus.clear_busy) earlyGrants++;
    end
    checkOutput("noClrWrites", writes, 32'd0);
    checkOutput("noClrDone", doneCount, 32'd0);
    checkOutput("noClrBusy", earlyGrants, 32'd0);
    applyStimulus(1'b1, 10'd3, 16'h1234, 1'b0, '0, '0, 1'b1);
    @(negedge clk);
    checkOutput("noClrGrant", 32'(bus.req0_ready), 32'd1);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    checkOutput("noClrWriteAddr", 32'(bus.addra), 32'd3);
`endif

    // Randomized traffic. Each requester holds its request until accepted.
    // Rare clear pulses are included.
    doReset();
    v0 = 1'b0; v1 = 1'b0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      acc0 = v0 && bus.req0_ready;
      acc1 = v1 && bus.req1_ready;
      if (!v0 || acc0) begin
        v0 = ($urandom_range(0, 3) != 0);
        a0 = AW'($urandom_range(0, 1023));
        d0 = DW'($urandom);
      end
      if (!v1 || acc1) begin
        v1 = ($urandom_range(0, 2) != 0);
        a1 = AW'($urandom_range(0, 1023));
        d1 = DW'($urandom);
      end
      st = ($urandom_range(0, 999) == 0);
      applyStimulus(v0, a0, d0, v1, a1, d1, st);
    end
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
